// File: rtl/trojan_pkg.sv
// Shared definitions for the trigger/payload trojan block: payload modes, FSM states, parameter check.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package trojan_pkg;

  // Payload types selected by the MODE parameter
  localparam int MODE_XOR    = 0;
  localparam int MODE_FORCE0 = 1;
  localparam int MODE_FORCE1 = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FIRE = 1'b1
  } state_t;

  // True when the parameter set describes a buildable block: the threshold must be
  // reachable by the counter without wrapping, the mode must be known, and a
  // non-sticky fire window must last at least one cycle.
  function automatic bit params_legal(input int cnt_w, input int thresh,
                                      input int mode, input int active_cyc);
    longint max_cnt;
    max_cnt = (longint'(1) << cnt_w) - 1;
    return (cnt_w >= 1) && (thresh >= 1) && (longint'(thresh) <= max_cnt) &&
           (mode >= MODE_XOR) && (mode <= MODE_FORCE1) && (active_cyc >= 1);
  endfunction

endpackage

// File: rtl/trig_edge_det.sv
// Mask/match compare on the trigger nets, previous-cycle condition register and rising-edge event.
// Latency: event is combinational from trigger nets; condition history is one register stage.
// Backpressure: none; i_en only gates the event, the history register always updates.
//   Ports: CK, rst_n (async active-low), i_en, i_trig[TRIG_W] -> o_event
module trig_edge_det
  import trojan_pkg::*;
#(
  parameter int                TRIG_W    = 2,
  parameter logic [TRIG_W-1:0] TRIG_MASK = {TRIG_W{1'b1}},
  parameter logic [TRIG_W-1:0] TRIG_VAL  = {TRIG_W{1'b1}}
) (
  input  logic              CK,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [TRIG_W-1:0] i_trig,
  output logic              o_event
);

  logic w_cond;
  logic r_cond_q;

  assign w_cond = ((i_trig & TRIG_MASK) == (TRIG_VAL & TRIG_MASK));

  // Resets to 1 so a condition already true when reset releases is not an edge.
  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      r_cond_q <= 1'b1;
    end else begin
      r_cond_q <= w_cond;
    end
  end

  assign o_event = w_cond & ~r_cond_q & i_en;

endmodule

// File: rtl/trojan_trigger_payload.sv
// Rare-event trojan: counts trigger-match edges, after THRESH of them fires and corrupts data_out.
// Latency: fire rises one cycle after the arming edge; payload mux is zero-latency combinational.
// Backpressure: none; en gates counting only, clr synchronously clears count/state/timer.
//   Ports: CK, rst_n (async active-low), en, clr, trig_in[TRIG_W], data_in[PAY_W]
//          -> data_out[PAY_W], fire, count[CNT_W]
module trojan_trigger_payload
  import trojan_pkg::*;
#(
  parameter int                TRIG_W     = 2,
  parameter logic [TRIG_W-1:0] TRIG_MASK  = {TRIG_W{1'b1}},
  parameter logic [TRIG_W-1:0] TRIG_VAL   = {TRIG_W{1'b1}},
  parameter int                CNT_W      = 4,
  parameter int                THRESH     = 7,
  parameter int                PAY_W      = 1,
  parameter int                MODE       = 0,
  parameter bit                STICKY     = 1'b0,
  parameter int                ACTIVE_CYC = 1
) (
  input  logic              CK,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [TRIG_W-1:0] trig_in,
  input  logic [PAY_W-1:0]  data_in,
  output logic [PAY_W-1:0]  data_out,
  output logic              fire,
  output logic [CNT_W-1:0]  count
);

  if (!params_legal(CNT_W, THRESH, MODE, ACTIVE_CYC)) begin : g_bad_params
    $error("trojan_trigger_payload: illegal CNT_W/THRESH/MODE/ACTIVE_CYC combination");
  end

  // Timer only needs to reach ACTIVE_CYC-1: it counts FIRE cycles already spent.
  localparam int                 TMR_W    = (ACTIVE_CYC > 1) ? $clog2(ACTIVE_CYC) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(ACTIVE_CYC - 1);
  localparam logic [CNT_W-1:0]   THRESH_C = CNT_W'(THRESH);

  state_t             r_state;
  logic               r_fire;
  logic [CNT_W-1:0]   r_count;
  logic [TMR_W-1:0]   r_timer;
  logic               w_event;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [PAY_W-1:0]   w_dout;

  trig_edge_det #(
    .TRIG_W    (TRIG_W),
    .TRIG_MASK (TRIG_MASK),
    .TRIG_VAL  (TRIG_VAL)
  ) u_edge (
    .CK      (CK),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_trig  (trig_in),
    .o_event (w_event)
  );

  // Counting only happens in IDLE where count < THRESH, so this never wraps.
  assign w_cnt_inc = r_count + 1'b1;

  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fire  <= 1'b0;
      r_count <= '0;
      r_timer <= '0;
    end else if (clr) begin
      r_state <= IDLE;
      r_fire  <= 1'b0;
      r_count <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_event) begin
            r_count <= w_cnt_inc;
            if (w_cnt_inc == THRESH_C) begin
              r_state <= FIRE;
              r_fire  <= 1'b1;
              r_timer <= '0;
            end
          end
        end
        FIRE: begin
          // Events are ignored here; count holds at THRESH until the window closes.
          if (!STICKY) begin
            if (r_timer == TMR_LAST) begin
              r_state <= IDLE;
              r_fire  <= 1'b0;
              r_count <= '0;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_fire  <= 1'b0;
        end
      endcase
    end
  end

  // r_fire clears asynchronously on reset, so pass-through is restored immediately.
  always_comb begin
    w_dout = data_in;
    if (r_fire) begin
      case (MODE)
        MODE_XOR:    w_dout = data_in ^ {PAY_W{1'b1}};
        MODE_FORCE0: w_dout = '0;
        MODE_FORCE1: w_dout = {PAY_W{1'b1}};
        default:     w_dout = data_in;
      endcase
    end
  end

  assign data_out = w_dout;
  assign fire     = r_fire;
  assign count    = r_count;

endmodule

// File: tb/tb_trojan_trigger_payload.sv
module tb_trojan_trigger_payload;

  logic       CK;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [1:0] trig;
  logic       data1;
  logic [3:0] data4;

  logic       dout_a, dout_c, dout_d;
  logic [3:0] dout_b;
  logic       fire_a, fire_b, fire_c, fire_d;
  logic [3:0] cnt_a, cnt_b, cnt_c, cnt_d;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int        dut;
    logic [3:0] cnt;
    logic      fire;
    logic [3:0] dout;
    string     nm;
  } exp_t;

  typedef struct {
    logic [1:0] trig;
    logic       en;
    logic       clr;
    logic [3:0] din;
    logic [3:0] cnt;
    logic       fire;
    logic [3:0] dout;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[16];

  // A: defaults (THRESH 7, XOR, 1-cycle fire)
  trojan_trigger_payload u_a (
    .CK(CK), .rst_n(rst_n), .en(en), .clr(clr), .trig_in(trig),
    .data_in(data1), .data_out(dout_a), .fire(fire_a), .count(cnt_a));

  // B: sticky, force-1, 4-bit payload, THRESH 3
  trojan_trigger_payload #(.STICKY(1'b1), .MODE(2), .PAY_W(4), .THRESH(3)) u_b (
    .CK(CK), .rst_n(rst_n), .en(en), .clr(clr), .trig_in(trig),
    .data_in(data4), .data_out(dout_b), .fire(fire_b), .count(cnt_b));

  // C: 5-cycle fire window, force-0
  trojan_trigger_payload #(.ACTIVE_CYC(5), .MODE(1)) u_c (
    .CK(CK), .rst_n(rst_n), .en(en), .clr(clr), .trig_in(trig),
    .data_in(data1), .data_out(dout_c), .fire(fire_c), .count(cnt_c));

  // D: THRESH 1
  trojan_trigger_payload #(.THRESH(1)) u_d (
    .CK(CK), .rst_n(rst_n), .en(en), .clr(clr), .trig_in(trig),
    .data_in(data1), .data_out(dout_d), .fire(fire_d), .count(cnt_d));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  function automatic logic [3:0] get_cnt(input int d);
    case (d)
      0: return cnt_a;
      1: return cnt_b;
      2: return cnt_c;
      default: return cnt_d;
    endcase
  endfunction

  function automatic logic get_fire(input int d);
    case (d)
      0: return fire_a;
      1: return fire_b;
      2: return fire_c;
      default: return fire_d;
    endcase
  endfunction

  function automatic logic [3:0] get_dout(input int d);
    case (d)
      0: return {3'b000, dout_a};
      1: return dout_b;
      2: return {3'b000, dout_c};
      default: return {3'b000, dout_d};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, push the expectation, then
  // compare 1 time unit after the rising edge.
  task automatic cyc(input int dut, input logic [1:0] t, input logic e, input logic c,
                     input logic [3:0] d, input logic [3:0] ec, input logic ef,
                     input logic [3:0] ed, input string nm);
    exp_t x;
    @(negedge CK);
    trig  = t;
    en    = e;
    clr   = c;
    data4 = d;
    data1 = d[0];
    exp_q.push_back('{dut, ec, ef, ed, nm});
    @(posedge CK);
    #1;
    x = exp_q.pop_front();
    chk({x.nm, "_count"}, get_cnt(x.dut), x.cnt);
    chk({x.nm, "_fire"}, {3'b000, get_fire(x.dut)}, {3'b000, x.fire});
    chk({x.nm, "_dout"}, get_dout(x.dut), x.dout);
  endtask

  task automatic do_reset(input logic [1:0] t);
    @(negedge CK);
    trig  = t;
    en    = 1'b1;
    clr   = 1'b0;
    data1 = 1'b1;
    data4 = 4'hA;
    rst_n = 1'b0;
    #1;
    chk("rst_count", cnt_a, 4'd0);
    chk("rst_fire", {3'b000, fire_a}, 4'd0);
    chk("rst_dout_a", {3'b000, dout_a}, 4'd1);
    chk("rst_dout_b", dout_b, 4'hA);
    @(negedge CK);
    rst_n = 1'b1;
  endtask

  task automatic arm_b(input logic [3:0] d);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b00, 1'b1, 1'b0, d, 4'(i), 1'b0, d, "b_lo");
      cyc(1, 2'b11, 1'b1, 1'b0, d, 4'(i + 1), (i == 2), (i == 2) ? 4'hF : d, "b_hi");
    end
  endtask

  initial begin
    int         n;
    logic [3:0] r;
    logic       e;
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    trig  = 2'b00;
    data1 = 1'b0;
    data4 = 4'h0;

    // Table: seven match edges on the default block, then the one-cycle fire window.
    tbl[0]  = '{2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 4'd1};
    tbl[2]  = '{2'b00, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 4'd1, 4'd2, 1'b0, 4'd1};
    tbl[4]  = '{2'b00, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0, 4'd0};
    tbl[5]  = '{2'b11, 1'b1, 1'b0, 4'd1, 4'd3, 1'b0, 4'd1};
    tbl[6]  = '{2'b00, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 4'd0};
    tbl[7]  = '{2'b11, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 4'd0};
    tbl[8]  = '{2'b00, 1'b1, 1'b0, 4'd1, 4'd4, 1'b0, 4'd1};
    tbl[9]  = '{2'b11, 1'b1, 1'b0, 4'd1, 4'd5, 1'b0, 4'd1};
    tbl[10] = '{2'b00, 1'b1, 1'b0, 4'd0, 4'd5, 1'b0, 4'd0};
    tbl[11] = '{2'b11, 1'b1, 1'b0, 4'd0, 4'd6, 1'b0, 4'd0};
    tbl[12] = '{2'b00, 1'b1, 1'b0, 4'd1, 4'd6, 1'b0, 4'd1};
    tbl[13] = '{2'b11, 1'b1, 1'b0, 4'd1, 4'd7, 1'b1, 4'd0};
    tbl[14] = '{2'b00, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd1};
    tbl[15] = '{2'b11, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0};

    do_reset(2'b00);
    for (int i = 0; i < 16; i++)
      cyc(0, tbl[i].trig, tbl[i].en, tbl[i].clr, tbl[i].din,
          tbl[i].cnt, tbl[i].fire, tbl[i].dout, $sformatf("tbl%0d", i));

    // Condition already true across reset release is not an event.
    do_reset(2'b11);
    for (int i = 0; i < 4; i++)
      cyc(0, 2'b11, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, "held_hi");
    cyc(0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, "held_drop");
    cyc(0, 2'b11, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 4'd1, "held_rise");

    // Sticky force-1 over a 4-bit payload, then clr.
    do_reset(2'b00);
    arm_b(4'h3);
    for (int i = 0; i < 22; i++) begin
      r = 4'($urandom_range(0, 15));
      cyc(1, (i % 2 == 1) ? 2'b11 : 2'b00, 1'b1, 1'b0, r, 4'd3, 1'b1, 4'hF, "b_sticky");
    end
    cyc(1, 2'b00, 1'b1, 1'b1, 4'h6, 4'd0, 1'b0, 4'h6, "b_clr");
    cyc(1, 2'b11, 1'b1, 1'b0, 4'h9, 4'd1, 1'b0, 4'h9, "b_after_clr");

    // Five-cycle force-0 window; edges and en=0 inside FIRE do not matter.
    do_reset(2'b00);
    for (int i = 0; i < 7; i++) begin
      cyc(2, 2'b00, 1'b1, 1'b0, 4'd1, 4'(i), 1'b0, 4'd1, "c_lo");
      cyc(2, 2'b11, 1'b1, 1'b0, 4'd1, 4'(i + 1), (i == 6), (i == 6) ? 4'd0 : 4'd1, "c_hi");
    end
    for (int k = 1; k <= 4; k++)
      cyc(2, (k % 2 == 1) ? 2'b00 : 2'b11, (k == 1) ? 1'b0 : 1'b1, 1'b0, 4'd1,
          4'd7, 1'b1, 4'd0, "c_fire");
    cyc(2, 2'b11, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd1, "c_exit");
    cyc(2, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, "c_idle");

    // en low on three of seven edges, then clr colliding with an event.
    do_reset(2'b00);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 2'b00, 1'b1, 1'b0, 4'd0, 4'(n), 1'b0, 4'd0, "en_lo");
      e = !(i == 1 || i == 3 || i == 5);
      if (e) n++;
      cyc(0, 2'b11, e, 1'b0, 4'd1, 4'(n), 1'b0, 4'd1, "en_hi");
    end
    cyc(0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 4'd0, "en_final");
    cyc(0, 2'b11, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, "clr_evt");
    cyc(0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, "clr_lo");
    cyc(0, 2'b11, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 4'd1, "clr_rise");

    // Asynchronous reset in the middle of a sticky fire.
    do_reset(2'b00);
    arm_b(4'h5);
    @(negedge CK);
    data4 = 4'h5;
    #2;
    chk("async_pre_fire", {3'b000, fire_b}, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("async_fire", {3'b000, fire_b}, 4'd0);
    chk("async_count", cnt_b, 4'd0);
    chk("async_dout", dout_b, 4'h5);
    @(negedge CK);
    rst_n = 1'b1;

    // THRESH = 1: first event fires on the next cycle, then window closes.
    do_reset(2'b00);
    cyc(3, 2'b00, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd1, "t1_lo");
    cyc(3, 2'b11, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 4'd0, "t1_fire");
    cyc(3, 2'b11, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd1, "t1_exit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
